// File: rtl/axi4_pkg.sv
// Shared AXI4 / AXI4-Stream field widths and payload types.
package axi4_pkg;

    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_DEST_W = 4;

    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_DEST_W-1:0] axi_dest_t;

endpackage

// File: rtl/axis_sink_pkg.sv
// Constants and state encoding for the AXI4-Stream sink checker.
package axis_sink_pkg;

    import axi4_pkg::*;

    localparam axi_data_t BASE_DATA_DEFAULT = 64'hdeadbeef00000000;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } sink_state_t;

endpackage

// File: rtl/axis_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a pseudo-random stall.
// stall_next_c reflects the LFSR value that will be held after the next edge,
// so the consumer can register its ready output in step with the LFSR.
module axis_stall_lfsr (
    input  logic CLK,
    input  logic RST,
    output logic stall_next_c
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_n;

    // Next LFSR value: shift left, feedback from taps 16,14,13,11.
    always_comb begin
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr_n;
        end
    end

    assign stall_next_c = (lfsr_n[1:0] == 2'b00);

endmodule

// File: rtl/axi4stream_sink_checker.sv
// AXI4-Stream receiving endpoint: captures beats into an indexed buffer and
// checks each against an incrementing data pattern, its own tdest and tlast.
// Optional macro AXIS_SINK_STALL_EN adds LFSR-driven backpressure.
module axi4stream_sink_checker
    import axi4_pkg::*;
    import axis_sink_pkg::*;
#(
    parameter int unsigned MY_ID     = 0,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned EXP_BEATS = 24,
    parameter axi_data_t   BASE_DATA = BASE_DATA_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enable,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [AXI_DATA_W-1:0]    s_tdata,
    input  logic [AXI_DEST_W-1:0]    s_tdest,
    input  logic                     s_tlast,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [AXI_DATA_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   beat_cnt,
    output logic [15:0]              err_cnt,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    sink_state_t      state;
    sink_state_t      state_n;
    logic [CNT_W-1:0] beat_cnt_n;
    logic [15:0]      err_cnt_n;
    logic             overflow_n;
    logic             wr_en_c;
    logic             beat_c;
    logic             beat_bad_c;
    logic             stall_next_c;
    axi_data_t        buf_mem [DEPTH];

`ifdef AXIS_SINK_STALL_EN
    axis_stall_lfsr u_stall (
        .CLK          (CLK),
        .RST          (RST),
        .stall_next_c (stall_next_c)
    );
`else
    assign stall_next_c = 1'b0;
`endif

    assign beat_c  = s_tvalid && s_tready;
    assign rd_data = buf_mem[rd_idx];

    // Next-state, counter and beat-check logic.
    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        err_cnt_n  = err_cnt;
        overflow_n = overflow;
        wr_en_c    = 1'b0;
        // One error per beat regardless of how many fields are wrong.
        beat_bad_c = (s_tdata != (BASE_DATA + AXI_DATA_W'(beat_cnt)))
                  || (s_tdest != AXI_DEST_W'(MY_ID))
                  || (s_tlast != (beat_cnt == CNT_W'(EXP_BEATS - 1)));
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RECV;
                end
            end
            RECV: begin
                if (beat_c) begin
                    wr_en_c    = 1'b1;
                    beat_cnt_n = beat_cnt + CNT_W'(1);
                    if (beat_bad_c && (err_cnt != 16'hFFFF)) begin
                        err_cnt_n = err_cnt + 16'd1;
                    end
                end
                if (beat_c && (beat_cnt_n == CNT_W'(EXP_BEATS))) begin
                    state_n = DONE;
                end else if (!enable) begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                if (beat_c) begin
                    overflow_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            s_tready <= 1'b0;
            beat_cnt <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_n;
            s_tready <= (state_n != IDLE) && !stall_next_c;
            beat_cnt <= beat_cnt_n;
            err_cnt  <= err_cnt_n;
            overflow <= overflow_n;
            done     <= (state_n == DONE);
            pass     <= (state_n == DONE) && (err_cnt_n == 16'd0) && !overflow_n;
        end
    end

    // Capture buffer; contents survive reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en_c) begin
            buf_mem[beat_cnt[IDX_W-1:0]] <= s_tdata;
        end
    end

endmodule
